alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; these ports come first in the port list.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 reqN_valid_i  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready_o  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_data1_i, reqN_data2_i  input  32  operands of requester N.
REQ-007 reqN_ctrl_i  input  3  ALU opcode: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL; 5-7 illegal.
REQ-008 rspN_valid_o  output  1  result for requester N is available.
REQ-009 rspN_ready_i  input  1  requester N consumes the result.
REQ-010 rspN_data_o  output  32  result; rspN_zero_o  output  1  result==0; rspN_err_o  output  1  illegal opcode.
REQ-011 alu_data1_o, alu_data2_o  output  32; alu_ctrl_o  output  3  operands and opcode to the shared external ALU.
REQ-012 alu_data_i  input  32; alu_zero_i  input  1  combinational result and zero flag from the shared ALU.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, RESP; reset state IDLE.
REQ-014 IDLE: reqN_ready_o is asserted combinationally for exactly the granted requester; no requester is granted when both valids are low.
REQ-015 Grant: only one valid -> that requester; both valid -> requester indicated by the priority pointer.
REQ-016 Accept (valid & ready) SHALL capture data1, data2, ctrl and owner id into registers and move to EXEC; reqN_ready_o is 0 in EXEC and RESP.
REQ-017 EXEC: alu_* outputs driven from captured registers; alu_data_i/alu_zero_i are registered into the result register at the end of the cycle; next state RESP.
REQ-018 Illegal opcode (5-7): alu_ctrl_o driven 3'd2 with zero operands; result is 32'd0, zero 1, err 1; legal opcodes give err 0.
REQ-019 RESP: rspN_valid_o is 1 only for the owner; data/zero/err are held stable until rspN_ready_i is 1.
REQ-020 The response handshake SHALL return to IDLE next cycle and set the priority pointer to the requester not just served.
REQ-021 Latency: accept in cycle T -> rsp valid in cycle T+2; minimum issue interval 3 cycles.
REQ-022 Outside EXEC, alu_data1_o/alu_data2_o/alu_ctrl_o SHALL be 0.
REQ-023 MUL returns the low 32 bits of the product; ADD/SUB wrap modulo 2^32.
REQ-024 Request inputs changing while the block is not in IDLE SHALL have no effect.
REQ-025 A requester SHALL NOT be granted twice in a row while the other holds valid continuously.

Reset
REQ-026 Reset SHALL return the FSM to IDLE, the priority pointer to 0 and the operand/result registers to 0.
REQ-027 After reset all ready, rsp_valid, err and zero outputs SHALL be 0, and rsp_data 0.
REQ-028 Reset in EXEC or RESP SHALL discard the in-flight operation; no rsp_valid pulse follows.

Structure
REQ-029 Package alu_pkg SHALL hold the opcode constants (ALU_AND..ALU_MUL), the opcode width, and the FSM state encoding.
REQ-030 Grant logic SHALL be sub-module rr_arb2 (two valids plus pointer in, one-hot grant out); the ALU stays external.

Verification
REQ-031 req0 ADD 5,7 alone -> ready0 in T, rsp0 valid at T+2, data 12, zero 0, err 0.
REQ-032 req0 and req1 valid after reset (SUB 9,9 / OR 0xF0,0x0F) -> req0 first (data 0, zero 1), then req1 (data 0xFF).
REQ-033 Both held valid for 4 ops -> grants alternate 0,1,0,1.
REQ-034 req1 ctrl=6 -> rsp1 data 0, zero 1, err 1; alu_ctrl_o 2 with zero operands in EXEC.
REQ-035 rsp0_ready_i low 5 cycles on MUL 0x10000,0x10000 -> rsp0 valid held, data 0, zero 1; no new grant until consumed.
REQ-036 rst_i in EXEC -> next cycle IDLE, all outputs 0, no rsp_valid for the dropped op.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encoding and FSM states.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_MUL = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Opcodes above MUL have no ALU meaning and are answered with an error.
  function automatic logic op_legal(input logic [ALU_OP_W-1:0] op);
    return (op <= ALU_MUL);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant: a lone requester always wins; on contention the pointer decides.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  // One-hot grant; zero when nobody is requesting.
  always_comb begin
    grant_o = 2'b00;
    if (valid_i == 2'b11) begin
      grant_o = ptr_i ? 2'b10 : 2'b01;
    end else begin
      grant_o = valid_i;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting; ready shown to the granted requester, accept captures op
// ST_EXEC | captured op driven to the ALU, result registered at cycle end
// ST_RESP | result presented to the owner until it is consumed
module alu_arbiter
  import alu_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req0_valid_i,
  output logic                req0_ready_o,
  input  logic [31:0]         req0_data1_i,
  input  logic [31:0]         req0_data2_i,
  input  logic [ALU_OP_W-1:0] req0_ctrl_i,
  input  logic                req1_valid_i,
  output logic                req1_ready_o,
  input  logic [31:0]         req1_data1_i,
  input  logic [31:0]         req1_data2_i,
  input  logic [ALU_OP_W-1:0] req1_ctrl_i,
  output logic                rsp0_valid_o,
  input  logic                rsp0_ready_i,
  output logic [31:0]         rsp0_data_o,
  output logic                rsp0_zero_o,
  output logic                rsp0_err_o,
  output logic                rsp1_valid_o,
  input  logic                rsp1_ready_i,
  output logic [31:0]         rsp1_data_o,
  output logic                rsp1_zero_o,
  output logic                rsp1_err_o,
  output logic [31:0]         alu_data1_o,
  output logic [31:0]         alu_data2_o,
  output logic [ALU_OP_W-1:0] alu_ctrl_o,
  input  logic [31:0]         alu_data_i,
  input  logic                alu_zero_i
);

  arb_state_e          state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                owner_q, owner_d;
  logic [31:0]         d1_q, d1_d;
  logic [31:0]         d2_q, d2_d;
  logic [ALU_OP_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]         res_q, res_d;
  logic                zero_q, zero_d;
  logic                err_q, err_d;
  logic [1:0]          grant;
  logic                rsp_done;

  rr_arb2 u_arb (
    .valid_i (({req1_valid_i, req0_valid_i})),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  // State, pointer, captured operands and result register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
      ctrl_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  // Next-state, handshakes and ALU drive.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    ctrl_d       = ctrl_q;
    res_d        = res_q;
    zero_d       = zero_q;
    err_d        = err_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    alu_data1_o  = '0;
    alu_data2_o  = '0;
    alu_ctrl_o   = '0;
    rsp_done     = owner_q ? rsp1_ready_i : rsp0_ready_i;

    case (state_q)
      ST_IDLE: begin
        req0_ready_o = grant[0];
        req1_ready_o = grant[1];
        if (grant != 2'b00) begin
          owner_d = grant[1];
          d1_d    = grant[1] ? req1_data1_i : req0_data1_i;
          d2_d    = grant[1] ? req1_data2_i : req0_data2_i;
          ctrl_d  = grant[1] ? req1_ctrl_i  : req0_ctrl_i;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_legal(ctrl_q)) begin
          alu_data1_o = d1_q;
          alu_data2_o = d2_q;
          alu_ctrl_o  = ctrl_q;
          res_d       = alu_data_i;
          zero_d      = alu_zero_i;
          err_d       = 1'b0;
        end else begin
          // Keep the ALU on a harmless add of zeros; the answer is fixed.
          alu_ctrl_o = ALU_ADD;
          res_d      = '0;
          zero_d     = 1'b1;
          err_d      = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_done) begin
          ptr_d   = ~owner_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response outputs are visible only to the owner while in RESP.
  always_comb begin
    rsp0_valid_o = (state_q == ST_RESP) && !owner_q;
    rsp1_valid_o = (state_q == ST_RESP) &&  owner_q;
    rsp0_data_o  = rsp0_valid_o ? res_q  : '0;
    rsp0_zero_o  = rsp0_valid_o ? zero_q : 1'b0;
    rsp0_err_o   = rsp0_valid_o ? err_q  : 1'b0;
    rsp1_data_o  = rsp1_valid_o ? res_q  : '0;
    rsp1_zero_o  = rsp1_valid_o ? zero_q : 1'b0;
    rsp1_err_o   = rsp1_valid_o ? err_q  : 1'b0;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the shared ALU.
module tb_alu_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_data1_i = '0, req0_data2_i = '0;
  logic [31:0] req1_data1_i = '0, req1_data2_i = '0;
  logic [2:0]  req0_ctrl_i = '0, req1_ctrl_i = '0;
  logic        rsp0_valid_o, rsp1_valid_o;
  logic        rsp0_ready_i = 1'b0, rsp1_ready_i = 1'b0;
  logic [31:0] rsp0_data_o, rsp1_data_o;
  logic        rsp0_zero_o, rsp1_zero_o, rsp0_err_o, rsp1_err_o;
  logic [31:0] alu_data1_o, alu_data2_o, alu_data_i;
  logic [2:0]  alu_ctrl_o;
  logic        alu_zero_i;

  int vectors = 0;
  int errors  = 0;

  always #5 clk_i = ~clk_i;

  alu_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i), .req0_ctrl_i(req0_ctrl_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i), .req1_ctrl_i(req1_ctrl_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i), .rsp0_data_o(rsp0_data_o),
    .rsp0_zero_o(rsp0_zero_o), .rsp0_err_o(rsp0_err_o),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i), .rsp1_data_o(rsp1_data_o),
    .rsp1_zero_o(rsp1_zero_o), .rsp1_err_o(rsp1_err_o),
    .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_data_i(alu_data_i), .alu_zero_i(alu_zero_i)
  );

  // External ALU environment model.
  always_comb begin
    case (alu_ctrl_o)
      3'd0:    alu_data_i = alu_data1_o & alu_data2_o;
      3'd1:    alu_data_i = alu_data1_o | alu_data2_o;
      3'd2:    alu_data_i = alu_data1_o + alu_data2_o;
      3'd3:    alu_data_i = alu_data1_o - alu_data2_o;
      3'd4:    alu_data_i = alu_data1_o * alu_data2_o;
      default: alu_data_i = 32'hDEAD_BEEF;
    endcase
    alu_zero_i = (alu_data_i == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " ready0"}, 32'(req0_ready_o), 32'd0);
    chk({tag, " ready1"}, 32'(req1_ready_o), 32'd0);
    chk({tag, " rsp0_valid"}, 32'(rsp0_valid_o), 32'd0);
    chk({tag, " rsp1_valid"}, 32'(rsp1_valid_o), 32'd0);
    chk({tag, " rsp0 d/z/e"}, rsp0_data_o | 32'(rsp0_zero_o) | 32'(rsp0_err_o), 32'd0);
    chk({tag, " rsp1 d/z/e"}, rsp1_data_o | 32'(rsp1_zero_o) | 32'(rsp1_err_o), 32'd0);
    chk({tag, " alu d1|d2|ctrl"}, alu_data1_o | alu_data2_o | 32'(alu_ctrl_o), 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_quiet("reset");

    // Single ADD on requester 0
    req0_valid_i = 1'b1; req0_ctrl_i = 3'd2; req0_data1_i = 32'd5; req0_data2_i = 32'd7;
    #1;
    chk("add ready0", 32'(req0_ready_o), 32'd1);
    chk("add ready1", 32'(req1_ready_o), 32'd0);
    tick();
    req0_valid_i = 1'b0; req0_data1_i = 32'd99;
    #1;
    chk("add exec ready0", 32'(req0_ready_o), 32'd0);
    chk("add exec alu_ctrl", 32'(alu_ctrl_o), 32'd2);
    chk("add exec alu_d1", alu_data1_o, 32'd5);
    chk("add exec alu_d2", alu_data2_o, 32'd7);
    chk("add exec rsp0_valid", 32'(rsp0_valid_o), 32'd0);
    tick();
    chk("add rsp0_valid", 32'(rsp0_valid_o), 32'd1);
    chk("add rsp1_valid", 32'(rsp1_valid_o), 32'd0);
    chk("add data", rsp0_data_o, 32'd12);
    chk("add zero", 32'(rsp0_zero_o), 32'd0);
    chk("add err", 32'(rsp0_err_o), 32'd0);
    chk("add resp alu_ctrl", 32'(alu_ctrl_o), 32'd0);
    rsp0_ready_i = 1'b1;
    tick();
    rsp0_ready_i = 1'b0;
    chk("add done rsp0_valid", 32'(rsp0_valid_o), 32'd0);

    // Contention right after reset: requester 0 wins first
    do_reset();
    req0_valid_i = 1'b1; req0_ctrl_i = 3'd3; req0_data1_i = 32'd9; req0_data2_i = 32'd9;
    req1_valid_i = 1'b1; req1_ctrl_i = 3'd1; req1_data1_i = 32'hF0; req1_data2_i = 32'h0F;
    #1;
    chk("both ready0", 32'(req0_ready_o), 32'd1);
    chk("both ready1", 32'(req1_ready_o), 32'd0);
    tick();
    chk("both exec ready1", 32'(req1_ready_o), 32'd0);
    tick();
    chk("sub rsp0_valid", 32'(rsp0_valid_o), 32'd1);
    chk("sub data", rsp0_data_o, 32'd0);
    chk("sub zero", 32'(rsp0_zero_o), 32'd1);
    rsp0_ready_i = 1'b1;
    tick();
    rsp0_ready_i = 1'b0; req0_valid_i = 1'b0;
    #1;
    chk("or ready1", 32'(req1_ready_o), 32'd1);
    tick();
    req1_valid_i = 1'b0;
    tick();
    chk("or rsp1_valid", 32'(rsp1_valid_o), 32'd1);
    chk("or rsp0_valid", 32'(rsp0_valid_o), 32'd0);
    chk("or data", rsp1_data_o, 32'h0000_00FF);
    chk("or zero", 32'(rsp1_zero_o), 32'd0);
    rsp1_ready_i = 1'b1;
    tick();
    rsp1_ready_i = 1'b0;

    // Both held valid: grants alternate 0,1,0,1
    do_reset();
    req0_valid_i = 1'b1; req0_ctrl_i = 3'd2; req0_data1_i = 32'd1; req0_data2_i = 32'd2;
    req1_valid_i = 1'b1; req1_ctrl_i = 3'd0;
    req1_data1_i = 32'hFF00_FF00; req1_data2_i = 32'h0FF0_0FF0;
    rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d ready0", i), 32'(req0_ready_o), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d ready1", i), 32'(req1_ready_o), (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      tick();
      if (i % 2 == 0) begin
        chk($sformatf("rr%0d rsp0_valid", i), 32'(rsp0_valid_o), 32'd1);
        chk($sformatf("rr%0d rsp0_data", i), rsp0_data_o, 32'd3);
      end else begin
        chk($sformatf("rr%0d rsp1_valid", i), 32'(rsp1_valid_o), 32'd1);
        chk($sformatf("rr%0d rsp1_data", i), rsp1_data_o, 32'h0F00_0F00);
      end
      @(posedge clk_i);
    end
    #1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;

    // Illegal opcode on requester 1
    do_reset();
    req1_valid_i = 1'b1; req1_ctrl_i = 3'd6; req1_data1_i = 32'd123; req1_data2_i = 32'd456;
    #1;
    chk("ill ready1", 32'(req1_ready_o), 32'd1);
    tick();
    req1_valid_i = 1'b0;
    chk("ill alu_ctrl", 32'(alu_ctrl_o), 32'd2);
    chk("ill alu_d1", alu_data1_o, 32'd0);
    chk("ill alu_d2", alu_data2_o, 32'd0);
    tick();
    chk("ill rsp1_valid", 32'(rsp1_valid_o), 32'd1);
    chk("ill data", rsp1_data_o, 32'd0);
    chk("ill zero", 32'(rsp1_zero_o), 32'd1);
    chk("ill err", 32'(rsp1_err_o), 32'd1);
    rsp1_ready_i = 1'b1;
    tick();
    rsp1_ready_i = 1'b0;

    // MUL overflow with response back-pressure; req1 must wait
    req0_valid_i = 1'b1; req0_ctrl_i = 3'd4;
    req0_data1_i = 32'h0001_0000; req0_data2_i = 32'h0001_0000;
    #1;
    chk("mul ready0", 32'(req0_ready_o), 32'd1);
    tick();
    req0_valid_i = 1'b0; req1_valid_i = 1'b1; req1_ctrl_i = 3'd2;
    req1_data1_i = 32'd4; req1_data2_i = 32'd4;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("mul hold%0d rsp0_valid", i), 32'(rsp0_valid_o), 32'd1);
      chk($sformatf("mul hold%0d data", i), rsp0_data_o, 32'd0);
      chk($sformatf("mul hold%0d zero", i), 32'(rsp0_zero_o), 32'd1);
      chk($sformatf("mul hold%0d err", i), 32'(rsp0_err_o), 32'd0);
      chk($sformatf("mul hold%0d ready1", i), 32'(req1_ready_o), 32'd0);
      tick();
    end
    rsp0_ready_i = 1'b1;
    tick();
    rsp0_ready_i = 1'b0;
    chk("mul done rsp0_valid", 32'(rsp0_valid_o), 32'd0);
    chk("after mul ready1", 32'(req1_ready_o), 32'd1);
    tick();
    req1_valid_i = 1'b0;
    tick();
    chk("after mul rsp1_data", rsp1_data_o, 32'd8);
    rsp1_ready_i = 1'b1;
    tick();
    rsp1_ready_i = 1'b0;

    // Reset while in EXEC drops the operation
    req0_valid_i = 1'b1; req0_ctrl_i = 3'd2; req0_data1_i = 32'd3; req0_data2_i = 32'd4;
    tick();
    req0_valid_i = 1'b0;
    chk("abort exec alu_d1", alu_data1_o, 32'd3);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_quiet("abort");
    tick();
    chk_quiet("abort+1");
    tick();
    chk_quiet("abort+2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
